// File: rtl/sd2_pkg.sv
// sd2_pkg: shared widths, full-scale and saturation helpers, LFSR constants for sd2_modulator.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sd2_pkg;

  // Default input sample width and integrator width.
  localparam int SD2_BW = 16;
  localparam int SD2_IW = SD2_BW + 3;

  // Dither LFSR: reset seed and Fibonacci tap mask (bits 15,13,12,10).
  localparam logic [15:0] SD2_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] SD2_LFSR_TAPS = 16'hB400;

  // Full-scale feedback magnitude for a bw-bit signed input: 2^(bw-1).
  function automatic logic signed [63:0] sd2_fs(input int bw);
    return 64'sd1 <<< (bw - 1);
  endfunction

  // Clamp v to the signed range of an iw-bit integrator; never wraps.
  function automatic logic signed [63:0] sd2_sat(input logic signed [63:0] v, input int iw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (iw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/sd2_modulator_if.sv
// sd2_modulator_if: sample-in / bitstream-out bundle of the modulator.
// Latency: n/a (wires only).
// Backpressure: none; one sample and one output bit per clock, no handshake.
interface sd2_modulator_if
  import sd2_pkg::*;
#(
  parameter int BW = SD2_BW
);
  logic signed [BW-1:0] sd_in;
  logic                 bs_out;

  // Source of samples / consumer of the bitstream.
  modport master (output sd_in, input bs_out);
  // The modulator itself.
  modport slave  (input sd_in, output bs_out);
endinterface

// File: rtl/sd2_lfsr.sv
// sd2_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the quantizer dither source.
// Latency: advances one step per clk; output is the current register.
// Backpressure: none; free-running.
module sd2_lfsr
  import sd2_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  // XOR of the tapped bits, shifted in at bit 0.
  assign w_fb = ^(r_lfsr & SD2_LFSR_TAPS);

  // Shift register: seeded on reset, one step every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SD2_LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/sd2_modulator.sv
// sd2_modulator: 2nd-order CIFB single-bit sigma-delta, NTF=(1-z^-1)^2, STF=z^-1; optional dither via SD2_DITHER_EN.
// Latency: sd_in sampled at edge n drives bs_out from edge n (bs_out is registered).
// Backpressure: none; one sample consumed and one bit produced every clk.
module sd2_modulator
  import sd2_pkg::*;
#(
  parameter int BW = SD2_BW,
  parameter int IW = BW + 3
)
(
  input logic            clk,
  input logic            rst_n,
  sd2_modulator_if.slave sd_if
);

  // Sums carry two guard bits above the integrator width so saturation sees the true value.
  localparam int SW = IW + 2;
  localparam logic signed [SW-1:0] FS_W = SW'(sd2_fs(BW));

  logic signed [IW-1:0] r_v1;
  logic signed [IW-1:0] r_v2;
  logic                 r_bs;

  logic signed [SW-1:0] w_x;
  logic signed [SW-1:0] w_y;
  logic signed [SW-1:0] w_s1;
  logic signed [SW-1:0] w_s2;
  logic signed [IW-1:0] w_v1_new;
  logic signed [IW-1:0] w_v2_new;
  logic                 w_dec;

  // Sign-extended input sample.
  assign w_x = {{(SW-BW){sd_if.sd_in[BW-1]}}, sd_if.sd_in};

  // 1-bit DAC feedback taken from the current output register.
  assign w_y = r_bs ? FS_W : -FS_W;

  // First integrator: input minus feedback, clamped.
  assign w_s1     = SW'(r_v1) + w_x - w_y;
  assign w_v1_new = IW'(sd2_sat(64'(w_s1), IW));

  // Second integrator: fed by the freshly updated first integrator, clamped.
  assign w_s2     = SW'(r_v2) + SW'(w_v1_new) - w_y;
  assign w_v2_new = IW'(sd2_sat(64'(w_s2), IW));

`ifdef SD2_DITHER_EN
  // Dither perturbs only the comparator decision; v2 itself is updated undithered.
  logic [15:0]          w_lfsr;
  logic signed [SW-1:0] w_d;
  logic signed [SW-1:0] w_q;

  sd2_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_lfsr (w_lfsr)
  );

  assign w_d   = SW'($signed(w_lfsr[3:0])) <<< (BW - 8);
  assign w_q   = SW'(w_v2_new) + w_d;
  // Zero counts as non-negative, so q = 0 decides 1.
  assign w_dec = ~w_q[SW-1];
`else
  // Zero counts as non-negative, so v2 = 0 decides 1.
  assign w_dec = ~w_v2_new[IW-1];
`endif

  // Loop state and output bit; reset clears everything so the first cycle uses y = -FS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= '0;
      r_v2 <= '0;
      r_bs <= 1'b0;
    end else begin
      r_v1 <= w_v1_new;
      r_v2 <= w_v2_new;
      r_bs <= w_dec;
    end
  end

  assign sd_if.bs_out = r_bs;

endmodule

// File: tb/tb_sd2_modulator.sv
// tb_sd2_modulator: directed and randomized stimulus for sd2_modulator against a behavioural model.
// Latency: output compared 1 time unit after each rising edge.
// Backpressure: none.
module tb_sd2_modulator;

  localparam int     BW   = 16;
  localparam longint FS   = 64'sd1 <<< (BW - 1);
  localparam longint IMAX = (64'sd1 <<< (BW + 2)) - 1;
  localparam longint IMIN = -(64'sd1 <<< (BW + 2));
`ifdef SD2_DITHER_EN
  localparam bit DITH = 1'b1;
  localparam int TOL  = 16;
`else
  localparam bit DITH = 1'b0;
  localparam int TOL  = 3;
`endif

  logic clk;
  logic rst_n;

  sd2_modulator_if #(.BW(BW)) sd_if ();

  sd2_modulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sd_if (sd_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  // Behavioural model state: integrators as plain integers, output bit, dither LFSR.
  typedef struct {
    longint     v1;
    longint     v2;
    bit         bs;
    bit [15:0]  lfsr;
  } mstate_t;

  mstate_t m;
  mstate_t m_ref;
  logic    hist[$];
  int      total;
  int      bad;
  int      ph_ones;
  int      ph_mism;
  int      ph_xs;
  int      ph_diff;
  int      fresh10k[8];
  int      exp_zero[8];

  function automatic longint clamp(input longint v);
    if (v > IMAX) return IMAX;
    if (v < IMIN) return IMIN;
    return v;
  endfunction

  function automatic mstate_t mreset();
    mstate_t s;
    s.v1   = 0;
    s.v2   = 0;
    s.bs   = 1'b0;
    s.lfsr = 16'hACE1;
    return s;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input longint x, input bit dith);
    mstate_t n;
    longint  y;
    longint  q;
    int      nib;
    n    = s;
    y    = s.bs ? FS : -FS;
    n.v1 = clamp(s.v1 + x - y);
    n.v2 = clamp(s.v2 + n.v1 - y);
    q    = n.v2;
    if (dith) begin
      nib = int'(s.lfsr[3:0]);
      if (nib >= 8) nib = nib - 16;
      q = q + longint'(nib) * 256;
    end
    n.bs   = (q >= 0);
    n.lfsr = {s.lfsr[14:0], s.lfsr[15] ^ s.lfsr[13] ^ s.lfsr[12] ^ s.lfsr[10]};
    return n;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input longint obs, input longint lo, input longint hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Hold reset across two edges, check the cleared output, release between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_bs", sd_if.bs_out, 0);
    rst_n   = 1'b1;
    m       = mreset();
    m_ref   = mreset();
    hist.delete();
    ph_ones = 0;
    ph_mism = 0;
    ph_xs   = 0;
    ph_diff = 0;
  endtask

  // Apply x for n cycles, stepping the model and tallying agreement and density.
  task automatic run(input int x, input int n);
    logic obs;
    for (int i = 0; i < n; i++) begin
      sd_if.sd_in = 16'(x);
      @(posedge clk);
      #1;
      m     = mstep(m, longint'(x), DITH);
      m_ref = mstep(m_ref, longint'(x), 1'b0);
      obs   = sd_if.bs_out;
      if ($isunknown(obs)) ph_xs++;
      if (obs !== m.bs) ph_mism++;
      if (obs === 1'b1) ph_ones++;
      if (m.bs != m_ref.bs) ph_diff++;
      if (hist.size() < 64) hist.push_back(obs);
    end
  endtask

  initial begin
    int found;
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    sd_if.sd_in = '0;
    exp_zero    = '{1, 1, 0, 1, 0, 0, 1, 1};

    // Zero input: start-up transient then period-4 limit cycle.
    do_reset();
    run(0, 40);
`ifndef SD2_DITHER_EN
    for (int i = 0; i < 8; i++) begin
      check($sformatf("zero_bit%0d", i), hist[i], exp_zero[i]);
    end
    begin
      int per_bad;
      per_bad = 0;
      for (int i = 8; i < 40; i++) begin
        if (hist[i] !== ((i % 4) >= 2)) per_bad++;
      end
      check("zero_period4_errs", per_bad, 0);
    end
`endif
    check("zero_model_mism", ph_mism, 0);

    // Positive DC: density (1 + 10000/32768)/2.
    do_reset();
    run(10000, 32768);
    for (int i = 0; i < 8; i++) fresh10k[i] = int'(hist[i]);
    check_rng("dc10000_ones", ph_ones, 21384 - TOL, 21384 + TOL);
    check("dc10000_model_mism", ph_mism, 0);
`ifdef SD2_DITHER_EN
    check_rng("dc10000_dither_diff", ph_diff, 1, 32768);
`endif

    // Negative DC.
    do_reset();
    run(-16384, 32768);
    check_rng("dcm16384_ones", ph_ones, 8192 - TOL, 8192 + TOL);
    check("dcm16384_model_mism", ph_mism, 0);

    // Random piecewise-constant input inside the stable range.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      run(int'($urandom_range(52428, 0)) - 26214, int'($urandom_range(64, 1)));
    end
    check("random_model_mism", ph_mism, 0);
    check("random_x_bits", ph_xs, 0);

    // Overload at negative full scale, then recovery at zero input.
    do_reset();
    run(-32768, 2000);
    check("ovl_x_bits", ph_xs, 0);
    check_rng("ovl_ones", ph_ones, 0, 99);
    check("ovl_model_mism", ph_mism, 0);
    run(0, 256);
    ph_ones = 0;
    run(0, 256);
    check_rng("recover_ones_256", ph_ones, 123, 133);
    check("recover_model_mism", ph_mism, 0);

    // Mid-stream asynchronous reset while the output is high.
    do_reset();
    run(10000, 100);
    found = 0;
    for (int i = 0; i < 32; i++) begin
      if (sd_if.bs_out === 1'b1) begin
        found = 1;
        break;
      end
      run(10000, 1);
    end
    check("midrst_found_high", found, 1);
    check("midrst_pre_mism", ph_mism, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_bs_immediate", sd_if.bs_out, 0);
    #2;
    rst_n   = 1'b1;
    m       = mreset();
    m_ref   = mreset();
    hist.delete();
    ph_mism = 0;
    run(10000, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("midrst_bit%0d", i), hist[i], fresh10k[i]);
    end
    check("midrst_model_mism", ph_mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
